// File: rtl/vga_timing_pkg.sv
// VGA mode presets and period arithmetic
// shared by the sync generator blocks.
`timescale 1ns/1ps
package vga_timing_pkg;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 56;
  localparam int VGA800_H_SYNC   = 120;
  localparam int VGA800_H_BP     = 64;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 37;
  localparam int VGA800_V_SYNC   = 6;
  localparam int VGA800_V_BP     = 23;

endpackage

// File: rtl/vga_axis_timing.sv
// One timing axis: wrapping counter with
// registered sync/active decoded from the next count.
`timescale 1ns/1ps
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b0,
  parameter int   CW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT  = CW'(ACTIVE);
  localparam logic [CW-1:0] SS   = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SE   = CW'(ACTIVE + FP + SYNC - 1);

  if (TOTAL - 1 >= (1 << CW)) begin : g_cw_chk
    $error("vga_axis_timing: CW too narrow");
  end

  logic [CW-1:0] r_count;
  logic          r_sync;
  logic          r_active;
  logic [CW-1:0] w_next;
  logic          w_wrap;
  logic          w_in_sync;

  assign w_wrap    = (r_count == LAST);
  assign w_next    = w_wrap ? '0 : r_count + 1'b1;
  assign w_in_sync = (w_next >= SS) && (w_next <= SE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= LAST;
      r_sync   <= ~POL;
      r_active <= 1'b0;
    end else if (adv) begin
      r_count  <= w_next;
      r_sync   <= w_in_sync ? POL : ~POL;
      r_active <= (w_next < ACT);
    end
  end

  assign count  = r_count;
  assign sync   = r_sync;
  assign active = r_active;
  assign wrap   = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock
// divider, h/v axes, line/frame strobes, frame counter.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 4,
  parameter int   CW       = 10,
  parameter int   FW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          h_sync,
  output logic          v_sync,
  output logic          vd_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HA_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] VA_LAST  = CW'(V_ACTIVE - 1);

  if (CLK_DIV < 1) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] r_div;
  logic          r_ls;
  logic          r_fs;
  logic          r_vd;
  logic [FW-1:0] r_fcnt;
  logic          w_tick;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_h_nact;
  logic          w_v_nact;
  logic          w_fwrap;

  assign w_tick  = en & (r_div == DIV_LAST);
  assign w_fwrap = w_tick & w_h_wrap & w_v_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  vga_axis_timing #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CW     (CW)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .adv    (w_tick),
    .count  (h_count),
    .sync   (h_sync),
    .active (w_h_act),
    .wrap   (w_h_wrap)
  );

  vga_axis_timing #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CW     (CW)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .adv    (w_tick & w_h_wrap),
    .count  (v_count),
    .sync   (v_sync),
    .active (w_v_act),
    .wrap   (w_v_wrap)
  );

  // Video-on from next h/v so it flips on the same edge as the counters
  assign w_h_nact = w_h_wrap | (w_h_act & (h_count != HA_LAST));
  assign w_v_nact = w_h_wrap
                  ? (w_v_wrap | (w_v_act & (v_count != VA_LAST)))
                  : w_v_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
      r_vd   <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_ls <= w_tick & w_h_wrap;
      r_fs <= w_fwrap;
      if (w_tick) begin
        r_vd <= w_h_nact & w_v_nact;
      end
      if (w_fwrap) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign pix_tick    = w_tick & rst;
  assign line_start  = r_ls & en;
  assign frame_start = r_fs & en;
  assign vd_on       = r_vd;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled-down mode with
// scoreboard model, plus an 800-wide CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIV = 4, CW = 6, FW = 16;

  localparam int H2A = VGA800_H_ACTIVE;
  localparam int H2S0 = VGA800_H_ACTIVE + VGA800_H_FP;
  localparam int H2S1 = H2S0 + VGA800_H_SYNC - 1;
  localparam int H2T = H2S1 + 1 + VGA800_H_BP;
  localparam int V2A = 3, V2F = 1, V2S = 1, V2B = 1;
  localparam int V2T = V2A + V2F + V2S + V2B;
  localparam int CW2 = 11, FW2 = 8;

  typedef struct packed {
    int div; int h; int v; int fc;
    bit ls; bit fs;
  } exp_t;

  localparam exp_t RST_E = '{div: 0, h: HT - 1, v: VT - 1,
                             fc: 0, ls: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;

  logic          pix_tick, h_sync, v_sync, vd_on;
  logic          line_start, frame_start;
  logic [CW-1:0] h_count, v_count;
  logic [FW-1:0] frame_cnt;

  logic           d2_tick, d2_hs, d2_vs, d2_vd, d2_ls, d2_fs;
  logic [CW2-1:0] d2_h, d2_v;
  logic [FW2-1:0] d2_fc;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  exp_t m;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .CLK_DIV(DIV), .CW(CW), .FW(FW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_tick(pix_tick),
    .h_count(h_count), .v_count(v_count),
    .h_sync(h_sync), .v_sync(v_sync), .vd_on(vd_on),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(VGA800_H_ACTIVE), .H_FP(VGA800_H_FP),
    .H_SYNC(VGA800_H_SYNC), .H_BP(VGA800_H_BP),
    .V_ACTIVE(V2A), .V_FP(V2F), .V_SYNC(V2S), .V_BP(V2B),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CLK_DIV(1), .CW(CW2), .FW(FW2)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .pix_tick(d2_tick),
    .h_count(d2_h), .v_count(d2_v),
    .h_sync(d2_hs), .v_sync(d2_vs), .vd_on(d2_vd),
    .line_start(d2_ls), .frame_start(d2_fs),
    .frame_cnt(d2_fc)
  );

  function automatic exp_t model_step(exp_t c, logic run);
    exp_t n = c;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (run) begin
      if (c.div == DIV - 1) begin
        n.div = 0;
        n.h = (c.h + 1) % HT;
        if (n.h == 0) begin
          n.v = (c.v + 1) % VT;
          n.ls = 1'b1;
          if (n.v == 0) begin
            n.fs = 1'b1;
            n.fc = (c.fc + 1) % (1 << FW);
          end
        end
      end else begin
        n.div = c.div + 1;
      end
    end
    return n;
  endfunction

  // Reference model: one expected state per clock edge
  initial begin
    m = RST_E;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m = RST_E;
        sb.delete();
      end else begin
        m = model_step(m, en);
      end
      sb.push_back(m);
    end
  end

  initial begin : mon
    exp_t e;
    logic [17:0] got, want;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        want = {CW'(e.h), CW'(e.v),
                (e.h < HA) && (e.v < VA),
                !((e.h >= HA + HF) && (e.h < HA + HF + HS)),
                !((e.v >= VA + VF) && (e.v < VA + VF + VS)),
                en && rst && (e.div == DIV - 1),
                e.ls && en, e.fs && en};
        got = {h_count, v_count, vd_on, h_sync, v_sync,
               pix_tick, line_start, frame_start};
        n_chk++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL sb_outputs t=%0t got %h expected %h",
                   $time, got, want);
        end
        n_chk++;
        if (int'(frame_cnt) !== e.fc) begin
          n_fail++;
          $display("FAIL sb_frame_cnt t=%0t got %0d expected %0d",
                   $time, frame_cnt, e.fc);
        end
      end
    end
  end

  task automatic test_reset();
    int w;
    logic [17:0] got;
    rst = 1'b0;
    en = 1'b1;
    #22;
    got = {h_count, v_count, vd_on, h_sync, v_sync,
           pix_tick, line_start, frame_start};
    n_chk++;
    if (got !== {CW'(HT - 1), CW'(VT - 1), 6'b011000}) begin
      n_fail++;
      $display("FAIL reset_values got %h expected %h", got,
               {CW'(HT - 1), CW'(VT - 1), 6'b011000});
    end
    rst = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pix_tick && w < 20);
    n_chk++;
    if (w != DIV - 1 || int'(h_count) != HT - 1) begin
      n_fail++;
      $display("FAIL first_tick clocks=%0d h=%0d expected %0d h=%0d",
               w, h_count, DIV - 1, HT - 1);
    end
    @(negedge clk);
    n_chk++;
    if (h_count !== 0 || v_count !== 0 || !vd_on ||
        !frame_start || !line_start || frame_cnt !== 1) begin
      n_fail++;
      $display("FAIL first_frame h=%0d v=%0d vd=%b fs=%b ls=%b fc=%0d expected 0 0 1 1 1 1",
               h_count, v_count, vd_on, frame_start, line_start,
               frame_cnt);
    end
  endtask

  task automatic test_line();
    int cnt, hs_lo, vd_cnt, hmin, hmax;
    cnt = 0; hs_lo = 0; vd_cnt = 0; hmin = 999; hmax = -1;
    do begin
      @(negedge clk);
      cnt++;
      if (!h_sync) begin
        hs_lo++;
        if (int'(h_count) < hmin) hmin = int'(h_count);
        if (int'(h_count) > hmax) hmax = int'(h_count);
      end
      if (vd_on) vd_cnt++;
    end while (!line_start && cnt < 500);
    n_chk++;
    if (cnt != HT * DIV) begin
      n_fail++;
      $display("FAIL line_period got %0d expected %0d", cnt, HT * DIV);
    end
    n_chk++;
    if (hs_lo != HS * DIV || hmin != HA + HF || hmax != HA + HF + HS - 1) begin
      n_fail++;
      $display("FAIL hsync_window clks=%0d h=%0d..%0d expected %0d h=%0d..%0d",
               hs_lo, hmin, hmax, HS * DIV, HA + HF, HA + HF + HS - 1);
    end
    n_chk++;
    if (vd_cnt != HA * DIV || v_count !== 1) begin
      n_fail++;
      $display("FAIL video_on clks=%0d v=%0d expected %0d v=1",
               vd_cnt, v_count, HA * DIV);
    end
  endtask

  task automatic test_frame();
    int cnt, vs_lines, vmin;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_start && cnt < 2000);
    n_chk++;
    if (!frame_start || frame_cnt !== 2) begin
      n_fail++;
      $display("FAIL second_frame fs=%b fc=%0d expected 1 2",
               frame_start, frame_cnt);
    end
    cnt = 0; vs_lines = 0; vmin = 999;
    do begin
      @(negedge clk);
      cnt++;
      if (line_start && !v_sync) begin
        vs_lines++;
        if (int'(v_count) < vmin) vmin = int'(v_count);
      end
    end while (!frame_start && cnt < 2000);
    n_chk++;
    if (cnt != HT * VT * DIV || frame_cnt !== 3) begin
      n_fail++;
      $display("FAIL frame_period got %0d fc=%0d expected %0d fc=3",
               cnt, frame_cnt, HT * VT * DIV);
    end
    n_chk++;
    if (vs_lines != VS || vmin != VA + VF) begin
      n_fail++;
      $display("FAIL vsync_lines got %0d first=%0d expected %0d first=%0d",
               vs_lines, vmin, VS, VA + VF);
    end
  endtask

  task automatic test_pause();
    int cnt, ticks;
    logic [CW-1:0] h0;
    bit paused;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!line_start && cnt < 200);
    cnt = 0; ticks = 0; paused = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (pix_tick) ticks++;
      if (!paused && h_count == CW'(10)) begin
        @(posedge clk);
        #2 en = 1'b0;
        h0 = h_count;
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          n_chk++;
          if (pix_tick || h_count !== h0 || line_start) begin
            n_fail++;
            $display("FAIL pause_hold tick=%b h=%0d ls=%b expected 0 %0d 0",
                     pix_tick, h_count, line_start, h0);
          end
        end
        #1 en = 1'b1;
        paused = 1'b1;
      end
    end while (!line_start && cnt < 500);
    n_chk++;
    if (ticks != HT || !paused) begin
      n_fail++;
      $display("FAIL pause_line_ticks got %0d paused=%b expected %0d 1",
               ticks, paused, HT);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    logic [17:0] got;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(h_count == CW'(12) && v_count == CW'(6)) && cnt < 2000);
    #2 rst = 1'b0;
    #1;
    got = {h_count, v_count, vd_on, h_sync, v_sync,
           pix_tick, line_start, frame_start};
    n_chk++;
    if (got !== {CW'(HT - 1), CW'(VT - 1), 6'b011000} ||
        frame_cnt !== 0 || cnt >= 2000) begin
      n_fail++;
      $display("FAIL async_reset got %h fc=%0d expected %h fc=0",
               got, frame_cnt, {CW'(HT - 1), CW'(VT - 1), 6'b011000});
    end
    #20 rst = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!pix_tick && cnt < 20);
    @(negedge clk);
    n_chk++;
    if (!frame_start || frame_cnt !== 1 || h_count !== 0 || v_count !== 0) begin
      n_fail++;
      $display("FAIL restart_frame fs=%b fc=%0d h=%0d v=%0d expected 1 1 0 0",
               frame_start, frame_cnt, h_count, v_count);
    end
  endtask

  task automatic test_param();
    int eh, ev, ef;
    logic [CW2+CW2+FW2+5:0] got, want;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    got = {d2_tick, d2_h, d2_v, d2_hs, d2_vs, d2_vd, d2_fs, d2_ls, d2_fc};
    want = {1'b0, CW2'(H2T - 1), CW2'(V2T - 1), 5'b00000, FW2'(0)};
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL p2_reset got %h expected %h", got, want);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    eh = H2T - 1; ev = V2T - 1; ef = 0;
    for (int i = 0; i < H2T * V2T + 1; i++) begin
      @(negedge clk);
      eh = (eh + 1) % H2T;
      if (eh == 0) begin
        ev = (ev + 1) % V2T;
        if (ev == 0) ef++;
      end
      want = {1'b1, CW2'(eh), CW2'(ev),
              (eh >= H2S0) && (eh <= H2S1),
              ev == V2A + V2F,
              (eh < H2A) && (ev < V2A),
              (eh == 0) && (ev == 0), eh == 0, FW2'(ef)};
      got = {d2_tick, d2_h, d2_v, d2_hs, d2_vs, d2_vd, d2_fs, d2_ls, d2_fc};
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL p2_sweep h=%0d v=%0d got %h expected %h",
                 eh, ev, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pause();
    test_async_reset();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. Resolution, porch and sync widths, sync polarities and the pixel-clock divide ratio are all set by parameters. Adds a clock-enable divider, pixel-tick, line/frame start strobes, a frame counter and a run enable. Sits between the system clock and the pixel/colour pipeline of the display subsystem.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of h_sync
VS_POL, 0, asserted level of v_sync
CLK_DIV, 4, system clocks per pixel (>=1)
CW, 10, width of h_count/v_count
FW, 16, width of frame_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; 0 freezes all state
pix_tick  out  1  one-clk pulse per pixel period
h_count  out  CW  current pixel column, 0..H_TOTAL-1
v_count  out  CW  current line, 0..V_TOTAL-1
h_sync  out  1  horizontal sync at HS_POL when asserted
v_sync  out  1  vertical sync at VS_POL when asserted
vd_on  out  1  video-on: h_count<H_ACTIVE and v_count<V_ACTIVE
line_start  out  1  one-clk pulse on the tick where h_count becomes 0
frame_start  out  1  one-clk pulse on the tick where (h,v) becomes (0,0)
frame_cnt  out  FW  number of frame wraps since reset, wraps modulo 2^FW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise. Elaboration error if H_TOTAL-1 or V_TOTAL-1 >= 2^CW, or if CLK_DIV < 1.
- Reset (rst=0, async): divider=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1, frame_cnt=0, pix_tick/line_start/frame_start=0, vd_on=0, h_sync=~HS_POL, v_sync=~VS_POL. Outputs are the consistent decode of the last pixel of a frame.
- Divider: counts 0..CLK_DIV-1 while en=1. pix_tick=1 during the clk where divider==CLK_DIV-1. CLK_DIV=1 gives pix_tick=1 on every enabled clk.
- On each pix_tick edge: h_count+1. If h_count==H_TOTAL-1, h_count becomes 0 and v_count+1. v_count wraps from V_TOTAL-1 to 0. No other wrap points.
- h_sync/v_sync/vd_on are registered. They are decoded from the next counter values, so they align with h_count/v_count on the same cycle with zero skew and no glitches.
- h_sync asserted when H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1. v_sync decoded the same way on v_count.
- line_start/frame_start are registered and high for exactly one clk, on the cycle where the new h=0 (and v=0) value appears.
- frame_cnt increments on each frame_start. The first frame after reset reads 1.
- en=0: divider, counters, syncs, vd_on and frame_cnt hold. pix_tick, line_start and frame_start are forced 0. On en returning to 1, the divider resumes from its held value with no lost or extra pixel.
- Reset mid-frame: immediate return to the reset values. The first tick after release produces frame_start.

Decomposition:
- Package vga_timing_pkg: localparams for the 640x480@60 and 800x600@72 timing sets, plus a function computing the total from active/fp/sync/bp.
- Sub-module vga_axis_timing(ACTIVE, FP, SYNC, BP, POL, CW):
  - ports clk, rst, adv, count, sync, active, wrap;
  - instantiated twice: horizontal with adv=pix_tick, vertical with adv=pix_tick&h_wrap.
- Top-level holds the divider, strobes and frame_cnt.

Test Plan:
- Reset held 20ns then released, defaults -> pix_tick every 4th clk. Before the first tick: h=799, v=524, vd_on=0, h_sync=v_sync=1. First tick gives h=0, v=0, vd_on=1, frame_start=1, line_start=1, frame_cnt=1.
- Run one line -> h_sync low exactly for h_count 656..751 (96 ticks, 384 clks). vd_on high for h 0..639. line_start period = 3200 clks.
- Run one full frame -> v_sync low only on lines 490..491. frame_start period = 800*525*4 = 1,680,000 clks. frame_cnt=2 at the second frame start.
- Pulse en=0 for 7 clks mid-line at h=300 -> counters and divider frozen, pix_tick=0 throughout. After re-enable, the line still totals exactly 800 ticks.
- Assert rst low asynchronously (between clk edges) at h=400, v=200 -> outputs take reset values immediately without a clk edge. Release -> next frame_start after one pixel tick.
- Parametrise CLK_DIV=1, HS_POL=1, 800x600@72 set -> pix_tick constant 1. h_sync is active-high for the correct window. H_TOTAL=1040 and V_TOTAL=666 wrap points verified.
